fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_sync_if.sv | 10 +
 rtl/fifo_sync.sv | 54 +++++
 tb/tb_fifo_sync.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_if.sv
// fifo_sync_if: handshake, data and status bundle for fifo_sync
interface fifo_sync_if #(parameter int WIDTH = 8, parameter int DEPTH_LOG2 = 4);
  logic clr, wr, rd, empty, full, almost_full, overflow, underflow;
  logic [WIDTH-1:0] datain, dataout;
  logic [DEPTH_LOG2:0] fullness;
  modport master(output clr, datain, wr, rd,
                 input dataout, fullness, empty, full, almost_full, overflow, underflow);
  modport slave(input clr, datain, wr, rd,
                output dataout, fullness, empty, full, almost_full, overflow, underflow);
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: first-word-fall-through shift-register FIFO with sticky over/underflow flags
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_LEVEL = 2**DEPTH_LOG2 - 2
) (
  input logic clk,
  input logic rst_n,
  fifo_sync_if.slave bus
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_C = (DEPTH_LOG2+1)'(AF_LEVEL);
  localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2:0] cnt, cnt_nx;
  logic [DEPTH_LOG2-1:0] ra;
  logic ovf, unf, wr_ok, rd_ok, empty_c, full_c;
  assign empty_c = cnt == '0;
  assign full_c = cnt == DEPTH_C;
  assign wr_ok = bus.wr & (~full_c | bus.rd);
  assign rd_ok = bus.rd & ~empty_c;
  assign ra = DEPTH_LOG2'(cnt - ONE);
  assign cnt_nx = (wr_ok & ~rd_ok) ? cnt + ONE : (rd_ok & ~wr_ok) ? cnt - ONE : cnt;
  assign bus.dataout = empty_c ? '0 : mem[ra];
  assign bus.fullness = cnt;
  assign bus.empty = empty_c;
  assign bus.full = full_c;
  assign bus.almost_full = cnt >= AF_C;
  assign bus.overflow = ovf;
  assign bus.underflow = unf;
  // storage is left unreset so it maps onto shift-register primitives
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[0] <= bus.datain;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (bus.clr) begin
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      ovf <= ovf | (bus.wr & ~wr_ok);
      unf <= unf | (bus.rd & ~rd_ok);
    end
  end
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed checks on the default FIFO plus randomized scoreboard runs at the size extremes
module tb_fifo_sync;
  typedef logic [63:0] q_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  q_t q1, q2;
  logic ov1 = 1'b0, un1 = 1'b0, ov2 = 1'b0, un2 = 1'b0;
  always #5 clk = ~clk;
  fifo_sync_if #(.WIDTH(8), .DEPTH_LOG2(4)) b0();
  fifo_sync_if #(.WIDTH(1), .DEPTH_LOG2(1)) b1();
  fifo_sync_if #(.WIDTH(64), .DEPTH_LOG2(8)) b2();
  fifo_sync #(.WIDTH(8), .DEPTH_LOG2(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  fifo_sync #(.WIDTH(1), .DEPTH_LOG2(1), .AF_LEVEL(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  fifo_sync #(.WIDTH(64), .DEPTH_LOG2(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic op0(input logic w, input logic r, input logic [7:0] d);
    b0.wr = w;
    b0.rd = r;
    b0.datain = d;
    @(negedge clk);
    b0.wr = 1'b0;
    b0.rd = 1'b0;
  endtask
  task automatic fill0();
    for (int i = 1; i <= 16; i++) op0(1'b1, 1'b0, 8'(i));
  endtask
  task automatic clr0();
    b0.clr = 1'b1;
    @(negedge clk);
    b0.clr = 1'b0;
  endtask
  // scoreboard: a queue with oldest at the front plus the two sticky flags
  task automatic model(ref q_t q, ref logic ov, ref logic un, input int depth,
                       input logic w, input logic r, input logic c, input logic [63:0] d);
    int n;
    logic wok, rok;
    n = q.size();
    if (c) begin
      q.delete();
      ov = 1'b0;
      un = 1'b0;
    end else begin
      wok = w && (n < depth || r);
      rok = r && n > 0;
      if (w && !wok) ov = 1'b1;
      if (r && !rok) un = 1'b1;
      if (rok) void'(q.pop_front());
      if (wok) q.push_back(d);
    end
  endtask
  task automatic cmp(input string t, input int depth, input int af, input q_t q,
                     input logic ov, input logic un, input logic [63:0] dout, input int fl,
                     input logic e, input logic f, input logic a, input logic o, input logic u);
    int n;
    n = q.size();
    chk({t, "_fullness"}, 64'(fl), 64'(n));
    chk({t, "_dataout"}, dout, n > 0 ? q[0] : 64'd0);
    chk({t, "_empty"}, 64'(e), 64'(n == 0));
    chk({t, "_full"}, 64'(f), 64'(n == depth));
    chk({t, "_afull"}, 64'(a), 64'(n >= af));
    chk({t, "_ovf"}, 64'(o), 64'(ov));
    chk({t, "_unf"}, 64'(u), 64'(un));
  endtask
  initial begin
    {b0.clr, b0.wr, b0.rd, b0.datain} = '0;
    {b1.clr, b1.wr, b1.rd, b1.datain} = '0;
    {b2.clr, b2.wr, b2.rd, b2.datain} = '0;
    repeat (2) @(negedge clk);
    chk("rst_fullness", 64'(b0.fullness), 64'd0);
    chk("rst_empty", 64'(b0.empty), 64'd1);
    chk("rst_full", 64'(b0.full), 64'd0);
    chk("rst_afull", 64'(b0.almost_full), 64'd0);
    chk("rst_dataout", 64'(b0.dataout), 64'd0);
    chk("rst_flags", 64'({b0.overflow, b0.underflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      op0(1'b1, 1'b0, 8'(i));
      chk("fill_afull", 64'(b0.almost_full), 64'(i >= 14));
      chk("fill_fullness", 64'(b0.fullness), 64'(i));
    end
    chk("fill_full", 64'(b0.full), 64'd1);
    chk("fill_dataout", 64'(b0.dataout), 64'h01);
    for (int i = 1; i <= 16; i++) begin
      chk("drain_order", 64'(b0.dataout), 64'(i));
      op0(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", 64'(b0.empty), 64'd1);
    chk("drain_dataout", 64'(b0.dataout), 64'd0);
    fill0();
    op0(1'b1, 1'b1, 8'hAA);
    chk("wrrd_full_fullness", 64'(b0.fullness), 64'd16);
    chk("wrrd_full_dataout", 64'(b0.dataout), 64'h02);
    for (int i = 0; i < 16; i++) begin
      chk("wrrd_order", 64'(b0.dataout), i < 15 ? 64'(i + 2) : 64'hAA);
      op0(1'b0, 1'b1, 8'h00);
    end
    chk("wrrd_unf_clean", 64'(b0.underflow), 64'd0);
    fill0();
    op0(1'b1, 1'b0, 8'h77);
    chk("ovf_set", 64'(b0.overflow), 64'd1);
    chk("ovf_fullness", 64'(b0.fullness), 64'd16);
    chk("ovf_dataout", 64'(b0.dataout), 64'h01);
    for (int i = 0; i < 10; i++) begin
      op0(1'b1, 1'b1, 8'(8'h80 + i));
      chk("ovf_sticky", 64'(b0.overflow), 64'd1);
    end
    chk("ovf_contents", 64'(b0.dataout), 64'h0B);
    clr0();
    chk("clr_ovf", 64'(b0.overflow), 64'd0);
    chk("clr_fullness", 64'(b0.fullness), 64'd0);
    op0(1'b1, 1'b1, 8'h5C);
    chk("unf_set", 64'(b0.underflow), 64'd1);
    chk("unf_fullness", 64'(b0.fullness), 64'd1);
    chk("unf_dataout", 64'(b0.dataout), 64'h5C);
    b0.clr = 1'b1;
    op0(1'b1, 1'b0, 8'hEE);
    b0.clr = 1'b0;
    chk("clr_discard", 64'(b0.fullness), 64'd0);
    chk("clr_unf", 64'(b0.underflow), 64'd0);
    for (int i = 0; i < 5; i++) op0(1'b1, 1'b0, 8'(8'h40 + i));
    chk("pre_arst_fullness", 64'(b0.fullness), 64'd5);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_fullness", 64'(b0.fullness), 64'd0);
    chk("arst_empty", 64'(b0.empty), 64'd1);
    chk("arst_dataout", 64'(b0.dataout), 64'd0);
    @(negedge clk);
    op0(1'b1, 1'b0, 8'h99);
    chk("rst_ignores_wr", 64'(b0.fullness), 64'd0);
    rst_n = 1'b1;
    op0(1'b1, 1'b0, 8'h33);
    chk("post_rst_dataout", 64'(b0.dataout), 64'h33);
    chk("post_rst_fullness", 64'(b0.fullness), 64'd1);
    for (int c = 0; c < 10000; c++) begin
      logic w, r, cl;
      logic [63:0] d;
      cmp("r1", 2, 1, q1, ov1, un1, 64'(b1.dataout), int'(b1.fullness),
          b1.empty, b1.full, b1.almost_full, b1.overflow, b1.underflow);
      cmp("r8", 256, 254, q2, ov2, un2, b2.dataout, int'(b2.fullness),
          b2.empty, b2.full, b2.almost_full, b2.overflow, b2.underflow);
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      cl = $urandom_range(0, 199) == 0;
      d = 64'($urandom_range(0, 1));
      b1.wr = w;
      b1.rd = r;
      b1.clr = cl;
      b1.datain = d[0];
      model(q1, ov1, un1, 2, w, r, cl, d);
      // alternate fill-heavy and drain-heavy phases so the deep FIFO reaches both ends
      w = $urandom_range(0, 9) < (((c / 600) % 2 == 0) ? 8 : 2);
      r = $urandom_range(0, 9) < (((c / 600) % 2 == 0) ? 2 : 8);
      cl = $urandom_range(0, 999) == 0;
      d = {$urandom, $urandom};
      b2.wr = w;
      b2.rd = r;
      b2.clr = cl;
      b2.datain = d;
      model(q2, ov2, un2, 256, w, r, cl, d);
      @(negedge clk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
